// File: rtl/plot_capture_if.sv
// plot_capture_if
//   Pixel-plot stream plus colour readback port between a drawing engine
//   (or a checker) and the frame capture block.
//   master : drives plots and read requests, receives read data
//   slave  : the capture block
//   Signals:
//     vga_x / vga_y / vga_colour / vga_plot : one plotted pixel per cycle
//     rd_en / rd_x / rd_y                   : read request
//     rd_colour / rd_valid                  : read data, one cycle later
interface plot_capture_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       rd_en;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [2:0] rd_colour;
    logic       rd_valid;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, rd_en, rd_x, rd_y,
        input  rd_colour, rd_valid
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, rd_en, rd_x, rd_y,
        output rd_colour, rd_valid
    );
endinterface

// File: rtl/plot_capture.sv
// plot_capture
//   Captures the pixel-plot stream into a WIDTH x HEIGHT x 3-bit frame
//   memory, with a registered readback port, accepted/rejected plot
//   counters and a bounding box of accepted plots.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset (starts a sweep)
//     bus            : plot stream and read port (plot_capture_if.slave)
//     clear          : one-cycle request to zero memory and statistics
//     busy           : high while the clear sweep runs
//     plot_count     : accepted plots, saturating
//     reject_count   : rejected plots, saturating
//     bbox_*         : extent of accepted plots since the last clear
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_CLEAR | sweeping clr_addr over the frame, writing 0; plots rejected
//   S_IDLE  | accepting plots; clear request starts a new sweep
module plot_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic                clk,
    input  logic                rst,
    plot_capture_if.slave       bus,
    input  logic                clear,
    output logic                busy,
    output logic [14:0]         plot_count,
    output logic [7:0]          reject_count,
    output logic                bbox_valid,
    output logic [7:0]          bbox_min_x,
    output logic [7:0]          bbox_max_x,
    output logic [6:0]          bbox_min_y,
    output logic [6:0]          bbox_max_y
);
    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [7:0]  X_LIM     = 8'(WIDTH);
    localparam logic [6:0]  Y_LIM     = 7'(HEIGHT);
    localparam logic [14:0] ROW_PITCH = 15'(WIDTH);
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_addr;

    logic [2:0]  mem [0:DEPTH-1];

    logic        plot_in_range, rd_in_range;
    logic [14:0] plot_addr, rd_addr;
    logic        clear_eff, accept, reject;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;

    // Constant multiply folds to (y<<7)+(y<<5) for the default 160 width.
    function automatic logic [14:0] addr_of(input logic [7:0] x, input logic [6:0] y);
        return 15'(y) * ROW_PITCH + 15'(x);
    endfunction

    assign plot_in_range = (bus.vga_x < X_LIM) && (bus.vga_y < Y_LIM);
    assign rd_in_range   = (bus.rd_x  < X_LIM) && (bus.rd_y  < Y_LIM);
    assign plot_addr     = addr_of(bus.vga_x, bus.vga_y);
    assign rd_addr       = addr_of(bus.rd_x, bus.rd_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state_q  <= state_d;
            // Parks at 0 outside the sweep so the next sweep starts there.
            clr_addr <= (state_q == S_CLEAR && clr_addr != LAST_ADDR) ? clr_addr + 15'd1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_addr == LAST_ADDR) state_d = S_IDLE;
            S_IDLE:  if (clear)                 state_d = S_CLEAR;
            default:                            state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_CLEAR);
        clear_eff = (state_q == S_IDLE) && clear;
        accept    = bus.vga_plot && (state_q == S_IDLE) && !clear && plot_in_range;
        // A plot colliding with an effective clear is dropped, not counted.
        reject    = bus.vga_plot && !accept && !clear_eff;
        wr_en     = busy || accept;
        wr_addr   = busy ? clr_addr : plot_addr;
        wr_data   = busy ? 3'd0 : bus.vga_colour;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Reads sample mem before this edge's write lands: read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_valid  <= 1'b0;
            bus.rd_colour <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_colour <= rd_in_range ? mem[rd_addr] : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            plot_count   <= '0;
            reject_count <= '0;
            bbox_valid   <= 1'b0;
            bbox_min_x   <= '0;
            bbox_max_x   <= '0;
            bbox_min_y   <= '0;
            bbox_max_y   <= '0;
        end else if (clear_eff) begin
            plot_count   <= '0;
            reject_count <= '0;
            bbox_valid   <= 1'b0;
        end else begin
            if (accept) begin
                if (plot_count != '1) plot_count <= plot_count + 15'd1;
                bbox_valid <= 1'b1;
                if (!bbox_valid) begin
                    bbox_min_x <= bus.vga_x;
                    bbox_max_x <= bus.vga_x;
                    bbox_min_y <= bus.vga_y;
                    bbox_max_y <= bus.vga_y;
                end else begin
                    if (bus.vga_x < bbox_min_x) bbox_min_x <= bus.vga_x;
                    if (bus.vga_x > bbox_max_x) bbox_max_x <= bus.vga_x;
                    if (bus.vga_y < bbox_min_y) bbox_min_y <= bus.vga_y;
                    if (bus.vga_y > bbox_max_y) bbox_max_y <= bus.vga_y;
                end
            end
            if (reject && reject_count != '1) reject_count <= reject_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_plot_capture.sv
// tb_plot_capture
//   Self-checking bench for plot_capture: vector table for single-cycle
//   plot/read behaviour, hand sequences for sweep, clear and saturation.
//   Read results are checked through an expected-value queue.
module tb_plot_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        busy;
    logic [14:0] plot_count;
    logic [7:0]  reject_count;
    logic        bbox_valid;
    logic [7:0]  bbox_min_x, bbox_max_x;
    logic [6:0]  bbox_min_y, bbox_max_y;

    plot_capture_if bus ();

    plot_capture dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clear        (clear),
        .busy         (busy),
        .plot_count   (plot_count),
        .reject_count (reject_count),
        .bbox_valid   (bbox_valid),
        .bbox_min_x   (bbox_min_x),
        .bbox_max_x   (bbox_max_x),
        .bbox_min_y   (bbox_min_y),
        .bbox_max_y   (bbox_max_y)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        bit         plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         rd;
        logic [7:0] rx;
        logic [6:0] ry;
        logic [2:0] erd;
        int         pc;
        int         rc;
        int         bv;
        int         mnx, mxx, mny, mxy;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_bbox(input int bv, input int mnx, input int mxx, input int mny, input int mxy);
        chk("bbox_valid", 32'(bbox_valid), bv);
        chk("bbox_min_x", 32'(bbox_min_x), mnx);
        chk("bbox_max_x", 32'(bbox_max_x), mxx);
        chk("bbox_min_y", 32'(bbox_min_y), mny);
        chk("bbox_max_y", 32'(bbox_max_y), mxy);
    endtask

    task automatic idle_inputs();
        clear          = 1'b0;
        bus.vga_plot   = 1'b0;
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.rd_en      = 1'b0;
        bus.rd_x       = '0;
        bus.rd_y       = '0;
    endtask

    task automatic drive_plot(input int x, input int y, input int c);
        bus.vga_plot   = 1'b1;
        bus.vga_x      = 8'(x);
        bus.vga_y      = 7'(y);
        bus.vga_colour = 3'(c);
    endtask

    task automatic drive_read(input int x, input int y, input int e);
        bus.rd_en = 1'b1;
        bus.rd_x  = 8'(x);
        bus.rd_y  = 7'(y);
        exp_q.push_back(3'(e));
    endtask

    // One clock: inputs set beforehand are sampled at the edge, outputs are
    // checked 1 time unit later, then inputs return to idle.
    task automatic cycle();
        logic       rd_was;
        logic [2:0] e;
        rd_was = bus.rd_en;
        @(posedge clk);
        #1;
        if (rd_was) begin
            e = exp_q.pop_front();
            chk("rd_valid", 32'(bus.rd_valid), 1);
            chk("rd_colour", 32'(bus.rd_colour), 32'(e));
        end else begin
            chk("rd_valid_idle", 32'(bus.rd_valid), 0);
        end
        idle_inputs();
    endtask

    initial begin
        int n;
        //           plot x    y    c  rd rx   ry   erd pc rc bv mnx mxx mny mxy
        vecs[0]  = '{0,  0,   0,   0, 1, 0,   0,   0,  0, 0, 0, 0,  0,  0,  0};
        vecs[1]  = '{0,  0,   0,   0, 1, 159, 119, 0,  0, 0, 0, 0,  0,  0,  0};
        vecs[2]  = '{0,  0,   0,   0, 1, 80,  60,  0,  0, 0, 0, 0,  0,  0,  0};
        vecs[3]  = '{1,  80,  60,  2, 0, 0,   0,   0,  1, 0, 1, 80, 80, 60, 60};
        vecs[4]  = '{0,  0,   0,   0, 1, 80,  60,  2,  1, 0, 1, 80, 80, 60, 60};
        vecs[5]  = '{1,  160, 10,  7, 0, 0,   0,   0,  1, 1, 1, 80, 80, 60, 60};
        vecs[6]  = '{1,  10,  120, 7, 0, 0,   0,   0,  1, 2, 1, 80, 80, 60, 60};
        vecs[7]  = '{1,  255, 127, 7, 0, 0,   0,   0,  1, 3, 1, 80, 80, 60, 60};
        vecs[8]  = '{0,  0,   0,   0, 1, 160, 10,  0,  1, 3, 1, 80, 80, 60, 60};
        vecs[9]  = '{0,  0,   0,   0, 1, 0,   11,  0,  1, 3, 1, 80, 80, 60, 60};
        vecs[10] = '{1,  0,   0,   5, 1, 0,   0,   0,  2, 3, 1, 0,  80, 0,  60};
        vecs[11] = '{0,  0,   0,   0, 1, 0,   0,   5,  2, 3, 1, 0,  80, 0,  60};
        vecs[12] = '{1,  159, 119, 3, 0, 0,   0,   0,  3, 3, 1, 0,  159, 0, 119};
        vecs[13] = '{1,  159, 119, 6, 1, 159, 119, 3,  4, 3, 1, 0,  159, 0, 119};
        vecs[14] = '{0,  0,   0,   0, 1, 159, 119, 6,  4, 3, 1, 0,  159, 0, 119};

        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_plot_count", 32'(plot_count), 0);
        chk("rst_reject_count", 32'(reject_count), 0);
        chk("rst_rd_colour", 32'(bus.rd_colour), 0);
        chk_bbox(0, 0, 0, 0, 0);

        // Sweep after reset release
        rst = 1'b0;
        n = 1;
        for (int i = 0; i < 20000 && busy; i++) begin
            cycle();
            if (busy) n++;
        end
        chk("reset_sweep_len", n, 19200);

        // Vector table
        foreach (vecs[i]) begin
            if (vecs[i].plot) drive_plot(vecs[i].x, vecs[i].y, vecs[i].c);
            if (vecs[i].rd)   drive_read(vecs[i].rx, vecs[i].ry, vecs[i].erd);
            cycle();
            chk("vec_plot_count", 32'(plot_count), vecs[i].pc);
            chk("vec_reject_count", 32'(reject_count), vecs[i].rc);
            chk_bbox(vecs[i].bv, vecs[i].mnx, vecs[i].mxx, vecs[i].mny, vecs[i].mxy);
        end

        // Clear with a colliding plot, plots and a second clear mid-sweep
        for (int i = 0; i < 10; i++) begin
            drive_plot(20 + i, 20 + i, 4);
            cycle();
        end
        chk("pre_clear_count", 32'(plot_count), 14);
        clear = 1'b1;
        drive_plot(5, 5, 6);
        cycle();
        chk("clear_busy", 32'(busy), 1);
        chk("clear_plot_count", 32'(plot_count), 0);
        chk("clear_reject_count", 32'(reject_count), 0);
        chk("clear_bbox_valid", 32'(bbox_valid), 0);
        n = 1;
        for (int i = 0; i < 3; i++) begin
            drive_plot(10, 10, 3);
            if (i == 0) drive_read(20, 20, 4);
            if (i == 2) drive_read(0, 0, 0);
            cycle();
            chk("sweep_reject_count", 32'(reject_count), i + 1);
            chk("sweep_busy", 32'(busy), 1);
            n++;
        end
        clear = 1'b1;
        drive_plot(10, 10, 3);
        cycle();
        chk("second_clear_rejects", 32'(reject_count), 4);
        if (busy) n++;
        for (int i = 0; i < 20000 && busy; i++) begin
            cycle();
            if (busy) n++;
        end
        chk("clear_sweep_len", n, 19200);
        chk("post_sweep_plot_count", 32'(plot_count), 0);
        drive_read(20, 20, 0);
        cycle();
        drive_read(159, 119, 0);
        cycle();

        // Read/write collision after clear
        drive_plot(0, 0, 7);
        drive_read(0, 0, 0);
        cycle();
        drive_read(0, 0, 7);
        cycle();
        chk("collide_plot_count", 32'(plot_count), 1);
        chk_bbox(1, 0, 0, 0, 0);

        // Full fill and saturation
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                drive_plot(x, y, 1);
                cycle();
            end
        end
        chk("fill_plot_count", 32'(plot_count), 19201);
        chk_bbox(1, 0, 159, 0, 119);
        for (int i = 0; i < 13600; i++) begin
            drive_plot(i % 160, i / 160, 1);
            cycle();
        end
        chk("sat_plot_count", 32'(plot_count), 32767);
        for (int i = 0; i < 300; i++) begin
            drive_plot(200, 0, 2);
            cycle();
        end
        chk("sat_reject_count", 32'(reject_count), 255);
        chk("sat_plot_count_hold", 32'(plot_count), 32767);
        chk_bbox(1, 0, 159, 0, 119);
        drive_read(0, 0, 1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive_read(int'($urandom_range(159)), int'($urandom_range(119)), 1);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/plot_capture.md
# plot_capture

Receiving end of the pixel-plot stream (`vga_x`/`vga_y`/`vga_colour`/`vga_plot`) that the drawing engines (fillscreen, circle, reuleaux) drive. It stores accepted plots into an on-chip 160x120x3 frame memory and exposes a registered readback port. It also keeps plot statistics and a bounding box. It sits beside, or in place of, the VGA adapter in simulation and on-chip self-check builds, so drawn frames can be inspected pixel by pixel.

## Interface
- `WIDTH`, default 160: frame width in pixels.
- `HEIGHT`, default 120: frame height in pixels.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  reset. **One clock; reset is synchronous and active-high.** Asserting it starts a clear sweep.
- `vga_x`  in  8  plot x coordinate.
- `vga_y`  in  7  plot y coordinate.
- `vga_colour`  in  3  plot colour.
- `vga_plot`  in  1  plot strobe; one pixel per cycle while high.
- `clear`  in  1  single-cycle request to zero the memory and all statistics.
- `busy`  out  1  high while a clear sweep is running.
- `rd_en`  in  1  read request.
- `rd_x`  in  8  read x coordinate.
- `rd_y`  in  7  read y coordinate.
- `rd_colour`  out  3  read data.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_colour`.
- `plot_count`  out  15  accepted plots; saturates at 32767.
- `reject_count`  out  8  rejected plots; saturates at 255.
- `bbox_valid`  out  1  high once at least one plot has been accepted since the last clear.
- `bbox_min_x`, `bbox_max_x`  out  8  horizontal extent of accepted plots.
- `bbox_min_y`, `bbox_max_y`  out  7  vertical extent of accepted plots.

## Operation
- **States.**
  - CLEAR: address counter `clr_addr` runs 0..WIDTH*HEIGHT-1 and writes 0 to one word per cycle. After the last address the block moves to IDLE.
  - IDLE: the block accepts plots.
- **Reset.**
  - `rst` high forces CLEAR with `clr_addr`=0.
  - The sweep begins on the first cycle `rst` is low, so `busy` is high for 19200 cycles after reset releases.
  - `rst` asserted mid-sweep restarts the sweep at address 0.
- **clear.**
  - Acts only in IDLE; ignored while `busy`=1.
  - Sets the state to CLEAR.
  - Zeroes `plot_count`, `reject_count` and `bbox_valid`.
- **Address.** addr = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits wide.
- **Plot acceptance.** A plot is accepted when `vga_plot`=1, state is IDLE, `clear`=0, x<WIDTH and y<HEIGHT.
- **Accepted plot.**
  - Writes `vga_colour` to addr.
  - Increments `plot_count`, saturating.
  - Updates the bbox: on the first accepted plot min=max=(x,y); afterwards a per-axis min/max compare.
- **Rejected plot.** Any plot that is not accepted increments `reject_count`, saturating. Causes are out-of-range coordinates or `busy`=1.
  - Exception: a plot in the same cycle as an effective `clear` is dropped without being counted, because the counters are being zeroed.
- **Read.**
  - `rd_en` is sampled every cycle, including during CLEAR.
  - An in-range read returns the memory word at addr.
  - An out-of-range read returns 0.
  - A read to the same addr as a same-cycle write returns the old data (read-before-write).
- **Reset values.**
  - `busy`=1.
  - `rd_valid`=0, `rd_colour`=0.
  - `plot_count`=0, `reject_count`=0.
  - `bbox_valid`=0; all `bbox_*` outputs = 0.
  - Memory contents are undefined until the sweep completes.

## Timing
- **Read latency.** `rd_en` high in cycle N gives `rd_valid`=1 and `rd_colour` in cycle N+1. Back-to-back reads are supported at one per cycle.
- **Write latency.** A plot accepted in cycle N is visible to an `rd_en` issued in cycle N+1 or later.
- **Statistics latency.** `plot_count`, `reject_count` and the bbox outputs reflect a cycle-N plot in cycle N+1.
- **busy timing.**
  - `busy` rises in the cycle after an effective `clear`.
  - `busy` falls in the cycle after address 19199 is written.
  - Plots are accepted starting in the first cycle with `busy`=0.
- **Sweep contents.** A read during the sweep to an address not yet cleared returns stale data. A read to an address that has been cleared returns 0.
- **Saturation.** When a counter is saturated, further events hold its value with no wrap.

## Test plan
- **Reset then sweep.** Hold `rst` 3 cycles, then release → `busy`=1 for exactly 19200 cycles. After that, reads of (0,0), (159,119) and (80,60) return 0 with `rd_valid` one cycle after `rd_en`.
- **Single plot readback.** Plot (80,60) colour 3'b010, then `rd_en` at (80,60) next cycle → `rd_colour`=3'b010. Also `plot_count`=1, `bbox_valid`=1 and the bbox equals (80,80,60,60).
- **Clipping.** Plot (160,10), (10,120) and (255,127) → memory unchanged, `reject_count`=3, `plot_count` unchanged. Reading (160,10) returns 0.
- **Clear.**
  - Plot 10 pixels, then pulse `clear` in the same cycle as a plot at (5,5) → counters go to 0, the (5,5) plot is dropped uncounted, and `busy` rises next cycle.
  - Plots during the sweep increment `reject_count`.
  - A second `clear` mid-sweep does not restart the sweep.
- **Read/write collision.** Write (0,0)=3'b111 and a same-cycle read of (0,0) after a clear → returns 0. A read the following cycle returns 3'b111.
- **Full fill.** Drive 19200 in-range plots in raster order with colour 3'b001, then 13600 more → `plot_count` saturates at 32767. The bbox is (0,159,0,119), and a random read returns 3'b001.
